char_rom_loader: RTL and testbench

CHAR_ROM_LOADER -- requirements
Module: char_rom_loader

---
 rtl/char_rom_pkg.sv | 28 ++
 rtl/char_rom_loader.sv | 169 ++++++++++++++++
 tb/tb_char_rom_loader.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_rom_pkg.sv
// Shared definitions for the character-ROM loader.
// Holds the glyph geometry (7-bit character code, 16 rows of 16 pixels),
// the character RAM address/data widths, the loader FSM state encoding
// and a helper that forms a character RAM address from code and row.
package char_rom_pkg;

  localparam int ASCII_W        = 7;
  localparam int ROW_W          = 4;
  localparam int ROWS_PER_GLYPH = 16;
  localparam int ADDR_W         = 11;
  localparam int DATA_W         = 16;

  // Loader FSM states. The ST_ prefix keeps the VERIFY state apart from
  // the VERIFY parameter of the loader.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Character RAM address of one glyph row: code in the upper bits, row below.
  function automatic logic [ADDR_W-1:0] glyph_addr(input logic [ASCII_W-1:0] code,
                                                   input logic [ROW_W-1:0]   row);
    return {code, row};
  endfunction

endpackage

// File: rtl/char_rom_loader.sv
// Character-ROM loader: writes one 16-row glyph into an external character
// RAM and, when VERIFY=1, reads the 16 rows back and compares them against
// a local shadow copy.
//
// Ports
//   pix_clk   sole clock, rising edge
//   rst_n     asynchronous active-low reset (release synchronised inside)
//   start     one-cycle load request, honoured only while idle
//   ascii     character code, latched when start is accepted
//   wdata     glyph row bitmap, row 0 first
//   wvalid    wdata valid; a beat moves when wvalid && wready
//   wready    loader accepts a row (only while writing)
//   rom_addr  character RAM address {ascii, row}
//   rom_di    character RAM write data
//   rom_we    byte write enables, 2'b11 on write cycles
//   rom_en    character RAM enable, high on every read or write cycle
//   rom_do    character RAM read data, one cycle after its address
//   busy      high whenever the loader is not idle
//   done      one-cycle pulse at the end of a load
//   err       sticky read-back mismatch flag, cleared by the next start
//   err_row   row of the first mismatch while err is high
module char_rom_loader
  import char_rom_pkg::*;
#(
  parameter bit VERIFY = 1'b1
) (
  input  logic              pix_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ASCII_W-1:0] ascii,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_di,
  output logic [1:0]        rom_we,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_do,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ROW_W-1:0]  err_row
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS_PER_GLYPH - 1);

  logic [1:0]         rst_sync;
  logic               rst_int_n;
  state_t             state, next_state;
  logic [ASCII_W-1:0] ascii_q;
  // One extra bit so the write counter can sit at 16 ("all rows taken")
  // instead of wrapping back to row 0.
  logic [ROW_W:0]     row;
  logic [ROW_W:0]     rd_row;
  logic               rd_v1, rd_v2;
  logic [ROW_W-1:0]   rd_r1, rd_r2;
  logic [DATA_W-1:0]  shadow [ROWS_PER_GLYPH];
  logic               beat;

  // Reset assertion reaches every register at once; release is delayed by
  // two pix_clk edges so all state leaves reset on the same clean edge.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];
  assign beat      = wready && wvalid;

  // FSM state register.
  always_ff @(posedge pix_clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  // Next-state and status outputs. Once row 15 is taken with VERIFY=0 the
  // FSM lingers in WRITE for that last write cycle with wready low, so done
  // lands one cycle after the final RAM write.
  always_comb begin
    next_state = state;
    wready     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        wready = !row[ROW_W];
        if (row[ROW_W])
          next_state = ST_DONE;
        else if (wvalid && row[ROW_W-1:0] == LAST_ROW && VERIFY)
          next_state = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (rd_v2 && rd_r2 == LAST_ROW) next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: RAM port registers, row counters and the read-back pipeline.
  // rd_v1/rd_r1 track the read address on the RAM port this cycle; rd_v2/rd_r2
  // track the cycle in which that read's data is on rom_do and gets compared.
  always_ff @(posedge pix_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ascii_q  <= '0;
      row      <= '0;
      rd_row   <= '0;
      rd_v1    <= 1'b0;
      rd_v2    <= 1'b0;
      rd_r1    <= '0;
      rd_r2    <= '0;
      rom_addr <= '0;
      rom_di   <= '0;
      rom_we   <= 2'b00;
      rom_en   <= 1'b0;
      err      <= 1'b0;
      err_row  <= '0;
    end else begin
      rom_we <= 2'b00;
      rom_en <= 1'b0;
      rd_v1  <= 1'b0;
      rd_v2  <= rd_v1;
      rd_r2  <= rd_r1;

      if (state == ST_IDLE && start) begin
        ascii_q <= ascii;
        row     <= '0;
        rd_row  <= '0;
        err     <= 1'b0;
        err_row <= '0;
      end

      if (beat) begin
        rom_addr <= glyph_addr(ascii_q, row[ROW_W-1:0]);
        rom_di   <= wdata;
        rom_we   <= 2'b11;
        rom_en   <= 1'b1;
        row      <= row + 1'b1;
      end

      if (state == ST_VERIFY && !rd_row[ROW_W]) begin
        rom_addr <= glyph_addr(ascii_q, rd_row[ROW_W-1:0]);
        rom_en   <= 1'b1;
        rd_v1    <= 1'b1;
        rd_r1    <= rd_row[ROW_W-1:0];
        rd_row   <= rd_row + 1'b1;
      end

      // Only the first mismatch of a load is recorded.
      if (state == ST_VERIFY && rd_v2 && !err && rom_do != shadow[rd_r2]) begin
        err     <= 1'b1;
        err_row <= rd_r2;
      end
    end
  end

  // Shadow copy of the rows written in this load, used as compare reference.
  always_ff @(posedge pix_clk) begin
    if (beat) shadow[row[ROW_W-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_char_rom_loader.sv
// Self-checking bench for char_rom_loader.
// u0 (VERIFY=1) is wired to a write-first character RAM model that can
// corrupt read data for rows 5 and 9; u1 (VERIFY=0) shares the same stimulus
// and is only used for its write/done timing. Expected RAM writes are queued
// as each beat is offered and popped by a monitor when the write appears.
module tb_char_rom_loader;

  logic        pix_clk = 1'b0;
  logic        rst_n   = 1'b1;
  logic        start   = 1'b0;
  logic [6:0]  ascii   = '0;
  logic [15:0] wdata   = '0;
  logic        wvalid  = 1'b0;

  logic        wready, rom_en, busy, done, err;
  logic [10:0] rom_addr;
  logic [15:0] rom_di, rom_do;
  logic [1:0]  rom_we;
  logic [3:0]  err_row;

  logic        u1_wready, u1_rom_en, u1_busy, u1_done, u1_err;
  logic [10:0] u1_rom_addr;
  logic [15:0] u1_rom_di;
  logic [15:0] u1_rom_do = '0;
  logic [1:0]  u1_rom_we;
  logic [3:0]  u1_err_row;

  logic [15:0] mem [2048];
  bit          corrupt = 1'b0;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0, rd_cnt = 0, rd_base = 0, done_cnt = 0, done_cyc = 0;
  int          u1_wr_cnt = 0, u1_rd_cnt = 0, u1_done_cnt = 0, u1_done_cyc = 0, u1_last_wr = 0;
  logic [6:0]  cur_ascii = '0;
  logic [26:0] exp_q [$];

  char_rom_loader #(.VERIFY(1'b1)) u0 (
    .pix_clk(pix_clk), .rst_n(rst_n), .start(start), .ascii(ascii),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .rom_addr(rom_addr),
    .rom_di(rom_di), .rom_we(rom_we), .rom_en(rom_en), .rom_do(rom_do),
    .busy(busy), .done(done), .err(err), .err_row(err_row)
  );

  char_rom_loader #(.VERIFY(1'b0)) u1 (
    .pix_clk(pix_clk), .rst_n(rst_n), .start(start), .ascii(ascii),
    .wdata(wdata), .wvalid(wvalid), .wready(u1_wready), .rom_addr(u1_rom_addr),
    .rom_di(u1_rom_di), .rom_we(u1_rom_we), .rom_en(u1_rom_en), .rom_do(u1_rom_do),
    .busy(u1_busy), .done(u1_done), .err(u1_err), .err_row(u1_err_row)
  );

  always #5 pix_clk = ~pix_clk;

  always @(posedge pix_clk) cyc <= cyc + 1;

  // Write-first single-port RAM with registered output.
  always @(posedge pix_clk) begin
    if (rom_en) begin
      if (rom_we == 2'b11) begin
        mem[rom_addr] <= rom_di;
        rom_do        <= rom_di;
      end else if (corrupt && (rom_addr[3:0] == 4'd5 || rom_addr[3:0] == 4'd9)) begin
        rom_do <= mem[rom_addr] ^ 16'h0100;
      end else begin
        rom_do <= mem[rom_addr];
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  task automatic monitor();
    logic [26:0] e;
    logic [3:0]  idx;
    forever begin
      @(negedge pix_clk);
      if (rom_en === 1'b1 && rom_we === 2'b11) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL write_unexpected: got addr %0h data %0h, required no write", rom_addr, rom_di);
        end else begin
          e = exp_q.pop_front();
          if ({rom_addr, rom_di} !== e) begin
            errors++;
            $display("[TB] FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                     rom_addr, rom_di, e[26:16], e[15:0]);
          end
        end
      end else if (rom_en === 1'b1 && rom_we === 2'b00) begin
        checks++;
        idx = 4'(rd_cnt - rd_base);
        if (rom_addr !== {cur_ascii, idx}) begin
          errors++;
          $display("[TB] FAIL read_addr: got %0h, required %0h", rom_addr, {cur_ascii, idx});
        end
        rd_cnt++;
      end else begin
        checks++;
        if (rom_we !== 2'b00 || rom_en !== 1'b0) begin
          errors++;
          $display("[TB] FAIL idle_port: got we %b en %b, required we 00 en 0", rom_we, rom_en);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (u1_rom_en === 1'b1 && u1_rom_we === 2'b11) begin
        u1_wr_cnt++;
        u1_last_wr = cyc;
      end
      if (u1_rom_en === 1'b1 && u1_rom_we === 2'b00) u1_rd_cnt++;
      if (u1_done === 1'b1) begin
        u1_done_cnt++;
        u1_done_cyc = cyc;
      end
    end
  endtask

  // Start a load of code ch and offer n_beats rows base+i. A junk beat is
  // offered in the start cycle and ascii is scrambled afterwards; both must
  // be ignored. With gaps set, every beat after the first follows a stall.
  task automatic apply_stimulus(input logic [6:0] ch, input logic [15:0] base, input bit gaps,
                                input int glitch_row, input int n_beats, output int sc);
    int n;
    @(posedge pix_clk); #1;
    start     = 1'b1;
    ascii     = ch;
    wvalid    = 1'b1;
    wdata     = 16'hBEEF;
    sc        = cyc;
    cur_ascii = ch;
    rd_base   = rd_cnt;
    @(posedge pix_clk); #1;
    start = 1'b0;
    ascii = 7'h55;
    for (int i = 0; i < n_beats; i++) begin
      if (gaps && i > 0) begin
        wvalid = 1'b0;
        wdata  = 16'hDEAD;
        @(posedge pix_clk); #1;
        checks++;
        if (rom_we !== 2'b00 || rom_en !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_port: got we %b en %b, required we 00 en 0", rom_we, rom_en);
        end
      end
      wvalid = 1'b1;
      wdata  = base + 16'(i);
      if (i == glitch_row) begin
        start = 1'b1;
        ascii = 7'h22;
      end
      n = 0;
      while (wready !== 1'b1 && n < 50) begin
        @(posedge pix_clk); #1;
        n++;
      end
      if (n == 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL wready_timeout: got wready %b, required 1", wready);
      end
      exp_q.push_back({ch, 4'(i), base + 16'(i)});
      @(posedge pix_clk); #1;
      start = 1'b0;
      ascii = 7'h55;
    end
    wvalid = 1'b0;
    wdata  = '0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 100) begin
      @(posedge pix_clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wready, rom_we, rom_en, rom_addr, rom_di, busy, done, err, err_row} !== 38'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %0h, required 0",
               {wready, rom_we, rom_en, rom_addr, rom_di, busy, done, err, err_row});
    end
    repeat (3) @(posedge pix_clk);
    #1;
    checks++;
    if ({busy, done, wready, rom_en} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %b, required 0000", {busy, done, wready, rom_en});
    end
    @(posedge pix_clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge pix_clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, w0 = wr_cnt, r0 = rd_cnt, sc;
    apply_stimulus(7'h41, 16'h0000, 1'b0, -1, 16, sc);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_busy: got %b, required 1", busy);
    end
    wait_done(d0);
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("[TB] FAIL b2b_done_count: got %0d, required %0d", done_cnt - d0, 1);
    end
    checks++;
    if (done_cyc - sc != 35) begin
      errors++;
      $display("[TB] FAIL b2b_latency: got %0d, required 35", done_cyc - sc);
    end
    checks++;
    if (wr_cnt - w0 != 16 || rd_cnt - r0 != 16) begin
      errors++;
      $display("[TB] FAIL b2b_counts: got writes %0d reads %0d, required 16 and 16", wr_cnt - w0, rd_cnt - r0);
    end
    checks++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: got err %b done %b busy %b, required 0 0 0", err, done, busy);
    end
  endtask

  task automatic test_stall();
    int d0 = done_cnt, w0 = wr_cnt, r0 = rd_cnt, sc;
    apply_stimulus(7'h41, 16'h0000, 1'b1, -1, 16, sc);
    wait_done(d0);
    checks++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL stall_done: got done %0d pending %0d, required 1 and 0", done_cnt - d0, exp_q.size());
    end
    checks++;
    if (wr_cnt - w0 != 16 || rd_cnt - r0 != 16 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_counts: got writes %0d reads %0d err %b, required 16 16 0",
               wr_cnt - w0, rd_cnt - r0, err);
    end
  endtask

  task automatic test_mismatch();
    int d0 = done_cnt, sc;
    corrupt = 1'b1;
    apply_stimulus(7'h30, 16'hA5A0, 1'b0, -1, 16, sc);
    wait_done(d0);
    corrupt = 1'b0;
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("[TB] FAIL mismatch_done: got %0d, required 1", done_cnt - d0);
    end
    checks++;
    if (err !== 1'b1 || err_row !== 4'd5) begin
      errors++;
      $display("[TB] FAIL mismatch_err: got err %b row %0d, required err 1 row 5", err, err_row);
    end
  endtask

  task automatic test_err_clear();
    int d0 = done_cnt, sc;
    repeat (2) @(posedge pix_clk);
    #1;
    checks++;
    if (err !== 1'b1 || err_row !== 4'd5) begin
      errors++;
      $display("[TB] FAIL err_sticky: got err %b row %0d, required err 1 row 5", err, err_row);
    end
    apply_stimulus(7'h31, 16'h0F00, 1'b0, -1, 16, sc);
    checks++;
    if (err !== 1'b0 || err_row !== 4'd0) begin
      errors++;
      $display("[TB] FAIL err_clear: got err %b row %0d, required err 0 row 0", err, err_row);
    end
    wait_done(d0);
    checks++;
    if (done_cnt != d0 + 1 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear_end: got done %0d err %b, required 1 and 0", done_cnt - d0, err);
    end
  endtask

  task automatic test_no_verify();
    int d0 = done_cnt, ud0 = u1_done_cnt, uw0 = u1_wr_cnt, ur0 = u1_rd_cnt, sc;
    apply_stimulus(7'h12, 16'h7000, 1'b0, -1, 16, sc);
    wait_done(d0);
    checks++;
    if (u1_done_cnt != ud0 + 1 || u1_done_cyc - sc != 18) begin
      errors++;
      $display("[TB] FAIL nv_done: got count %0d at %0d, required 1 at 18", u1_done_cnt - ud0, u1_done_cyc - sc);
    end
    checks++;
    if (u1_done_cyc - u1_last_wr != 1) begin
      errors++;
      $display("[TB] FAIL nv_after_write: got %0d, required 1", u1_done_cyc - u1_last_wr);
    end
    checks++;
    if (u1_rd_cnt != ur0 || u1_wr_cnt - uw0 != 16) begin
      errors++;
      $display("[TB] FAIL nv_counts: got reads %0d writes %0d, required 0 and 16", u1_rd_cnt - ur0, u1_wr_cnt - uw0);
    end
  endtask

  task automatic test_ignored();
    int d0 = done_cnt, w0 = wr_cnt, sc;
    wvalid = 1'b1;
    wdata  = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      @(posedge pix_clk); #1;
      checks++;
      if (wready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_wready: got %b, required 0", wready);
      end
    end
    wvalid = 1'b0;
    @(posedge pix_clk); #1;
    checks++;
    if (wr_cnt != w0) begin
      errors++;
      $display("[TB] FAIL idle_write: got %0d writes, required 0", wr_cnt - w0);
    end
    apply_stimulus(7'h52, 16'h3300, 1'b0, 6, 16, sc);
    wait_done(d0);
    checks++;
    if (done_cnt != d0 + 1 || wr_cnt - w0 != 16 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignored_load: got done %0d writes %0d err %b, required 1 16 0",
               done_cnt - d0, wr_cnt - w0, err);
    end
  endtask

  task automatic test_reset_midload();
    int d0 = done_cnt, w0, sc;
    apply_stimulus(7'h66, 16'h5500, 1'b0, -1, 7, sc);
    #5;
    checks++;
    if (busy !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL midload_state: got busy %b pending %0d, required 1 and 0", busy, exp_q.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wready, rom_we, rom_en, rom_addr, rom_di, busy, done, err, err_row} !== 38'h0) begin
      errors++;
      $display("[TB] FAIL midload_reset: got %0h, required 0",
               {wready, rom_we, rom_en, rom_addr, rom_di, busy, done, err, err_row});
    end
    repeat (3) @(posedge pix_clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge pix_clk);
    #1;
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("[TB] FAIL midload_no_done: got %0d, required 0", done_cnt - d0);
    end
    w0 = wr_cnt;
    apply_stimulus(7'h7F, 16'hC0C0, 1'b0, -1, 16, sc);
    wait_done(d0);
    checks++;
    if (done_cnt != d0 + 1 || wr_cnt - w0 != 16 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reload: got done %0d writes %0d pending %0d, required 1 16 0",
               done_cnt - d0, wr_cnt - w0, exp_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_back_to_back();
    test_stall();
    test_mismatch();
    test_err_clear();
    test_no_verify();
    test_ignored();
    test_reset_midload();
    repeat (3) @(posedge pix_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
